// File: rtl/bitwise_fold_unit_if.sv
// bitwise_fold_unit_if
//   Bundles the data/control inputs and registered result outputs of
//   bitwise_fold_unit. clk and rst_n stay plain ports on the module.
//   master : the block driving operands/control and observing results.
//   slave  : the bitwise_fold_unit itself.
//   Signals:
//     in_a, in_b  operands (in_a is the fold sample stream)
//     op          00 XOR, 01 AND, 10 OR, 11 XNOR
//     mode        0 pairwise, 1 fold (sampled in IDLE only)
//     start, len  fold start strobe and burst length (0 = 2^CNT_W)
//     in_valid    input sample qualifier
//     abort       cancels a fold in progress
//     out_data, out_valid, out_par  registered result, strobe, parity
//     busy, count fold-in-progress flag and samples consumed
interface bitwise_fold_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       op;
  logic             mode;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             abort;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_par;
  logic             busy;
  logic [CNT_W-1:0] count;

  modport master (
    output in_a, in_b, op, mode, start, len, in_valid, abort,
    input  out_data, out_valid, out_par, busy, count
  );

  modport slave (
    input  in_a, in_b, op, mode, start, len, in_valid, abort,
    output out_data, out_valid, out_par, busy, count
  );
endinterface

// File: rtl/bitwise_fold_unit.sv
// bitwise_fold_unit
//   Registered bitwise logic unit. Pairwise mode applies op to in_a/in_b
//   every valid cycle. Fold mode reduces a burst of 1..2^CNT_W in_a samples
//   into one word with the op latched at start.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    bitwise_fold_unit_if.slave (operands, control, results)
module bitwise_fold_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  bitwise_fold_unit_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_FOLD
  } state_t;

  typedef enum logic [1:0] {
    OP_XOR  = 2'b00,
    OP_AND  = 2'b01,
    OP_OR   = 2'b10,
    OP_XNOR = 2'b11
  } op_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [WIDTH-1:0] op_fn(
    input op_t              o,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    case (o)
      OP_XOR:  res = a ^ b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      default: res = ~(a ^ b);
    endcase
    return res;
  endfunction

  // Value that leaves the other operand unchanged under op.
  function automatic logic [WIDTH-1:0] ident_fn(input op_t o);
    logic [WIDTH-1:0] res;
    if (o == OP_AND || o == OP_XNOR) res = '1;
    else                             res = '0;
    return res;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  op_t              r_op_q;
  logic [CNT_W-1:0] r_len_q;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_par;
  logic             r_out_valid;

  op_t              w_op_in;
  logic [WIDTH-1:0] w_pair_res;
  logic [WIDTH-1:0] w_first_res;
  logic [WIDTH-1:0] w_fold_res;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_final;

  always_comb begin
    w_op_in     = op_t'(bus.op);
    w_pair_res  = op_fn(w_op_in, bus.in_a, bus.in_b);
    w_first_res = op_fn(w_op_in, ident_fn(w_op_in), bus.in_a);
    w_fold_res  = op_fn(r_op_q, r_acc, bus.in_a);
    // len_q = 0 wraps to all-ones here, giving 2^CNT_W samples.
    w_len_m1    = r_len_q - ONE;
    w_final     = (r_count == w_len_m1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_op_q      <= OP_XOR;
      r_len_q     <= '0;
      r_out_data  <= '0;
      r_out_par   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!bus.mode) begin
            if (bus.in_valid) begin
              r_out_data  <= w_pair_res;
              r_out_par   <= ^w_pair_res;
              r_out_valid <= 1'b1;
            end
          end else if (bus.start) begin
            r_op_q  <= w_op_in;
            r_len_q <= bus.len;
            if (!bus.in_valid) begin
              r_acc   <= ident_fn(w_op_in);
              r_count <= '0;
              r_state <= S_FOLD;
            end else begin
              // Start cycle already carries the first sample.
              r_acc <= w_first_res;
              if (bus.len == ONE) begin
                r_out_data  <= bus.in_a;
                r_out_par   <= ^bus.in_a;
                r_out_valid <= 1'b1;
                r_count     <= '0;
              end else begin
                r_count <= ONE;
                r_state <= S_FOLD;
              end
            end
          end
        end
        S_FOLD: begin
          // abort wins over a same-cycle final sample.
          if (bus.abort) begin
            r_acc   <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
          end else if (bus.in_valid) begin
            if (w_final) begin
              r_out_data  <= w_fold_res;
              r_out_par   <= ^w_fold_res;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_count     <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_acc   <= w_fold_res;
              r_count <= r_count + ONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_par   = r_out_par;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state == S_FOLD);
  assign bus.count     = r_count;

endmodule
